// File: rtl/ran_pkg.sv
// Shared types and constants for the random-bit harvest sequencer.
package ran_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRECH = 3'd1,
    S_EVAL  = 3'd2,
    S_CAPT  = 3'd3,
    S_PACK  = 3'd4,
    S_HOLD  = 3'd5
  } ran_state_t;

  localparam int unsigned SYNC_STAGES    = 2;
  localparam int unsigned MIN_SETTLE_CYC = SYNC_STAGES + 1;

endpackage

// File: rtl/ran_bit_packer.sv
// LSB-first bit accumulator. Stops accepting bits once the word is full; clear wins over strobe.
module ran_bit_packer #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              strobe,
  input  logic              clear,
  output logic [WORD_W-1:0] acc,
  output logic              full_c
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  logic [CNT_W-1:0] bit_cnt;

  assign full_c = (bit_cnt == CNT_W'(WORD_W));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (strobe && !full_c) begin
      acc     <= acc | (WORD_W'(bit_in) << bit_cnt);
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ran_harvest_ctrl.sv
// Sequencer for the dual-latch random-bit array: enable pulsing, sync/capture, word packing.
// Define RAN_VN_DEBIAS_EN to consume cells in pairs with von Neumann debiasing.
module ran_harvest_ctrl
  import ran_pkg::*;
#(
  parameter int unsigned N_BLOCKS   = 12,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned RESET_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_run,
  output logic                o_enb,
  input  logic [N_BLOCKS-1:0] i_block_Qs,
  output logic [WORD_W-1:0]   o_word,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_busy
);

  localparam int unsigned IDX_W  = $clog2(N_BLOCKS);
  localparam int unsigned PH_MAX = (RESET_CYC > SETTLE_CYC) ? RESET_CYC : SETTLE_CYC;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
`ifdef RAN_VN_DEBIAS_EN
  localparam int unsigned STEPS  = N_BLOCKS / 2;
`else
  localparam int unsigned STEPS  = N_BLOCKS;
`endif

  ran_state_t          state, state_n;
  logic [PH_W-1:0]     phase, phase_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic                cap_left, cap_left_n;
  logic [N_BLOCKS-1:0] cap, cap_n;
  logic [N_BLOCKS-1:0] sync [SYNC_STAGES];
  logic [WORD_W-1:0]   word_n;
  logic                valid_n, enb_n, busy_n;

  logic                strobe_c, clear_c, take_c, bit_c, full_c;
  logic [WORD_W-1:0]   acc;

  // Select the current harvested bit (or cell pair) from the capture register.
`ifdef RAN_VN_DEBIAS_EN
  logic [IDX_W:0] pair_pos;
  logic           hi_c;
  assign pair_pos = {idx, 1'b0};
  assign bit_c    = |(cap & (N_BLOCKS'(1) << pair_pos));
  assign hi_c     = |(cap & (N_BLOCKS'(2) << pair_pos));
  assign take_c   = bit_c ^ hi_c;
`else
  assign bit_c    = |(cap & (N_BLOCKS'(1) << idx));
  assign take_c   = 1'b1;
`endif

  ran_bit_packer #(.WORD_W(WORD_W)) u_packer (
    .clk    (i_clock),
    .rst_n  (i_reset_n),
    .bit_in (bit_c),
    .strobe (strobe_c),
    .clear  (clear_c),
    .acc    (acc),
    .full_c (full_c)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state    <= S_IDLE;
      phase    <= '0;
      idx      <= '0;
      cap_left <= 1'b0;
      cap      <= '0;
      o_word   <= '0;
      o_valid  <= 1'b0;
      o_enb    <= 1'b0;
      o_busy   <= 1'b0;
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync[s] <= '0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      idx      <= idx_n;
      cap_left <= cap_left_n;
      cap      <= cap_n;
      o_word   <= word_n;
      o_valid  <= valid_n;
      o_enb    <= enb_n;
      o_busy   <= busy_n;
      sync[0]  <= i_block_Qs;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync[s] <= sync[s-1];
    end
  end

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    idx_n      = idx;
    cap_left_n = cap_left;
    cap_n      = cap;
    word_n     = o_word;
    valid_n    = o_valid;
    strobe_c   = 1'b0;
    clear_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_run) begin
          state_n = S_PRECH;
          phase_n = '0;
        end
      end
      S_PRECH: begin
        if (phase == PH_W'(RESET_CYC - 1)) begin
          state_n = S_EVAL;
          phase_n = '0;
        end else begin
          phase_n = phase + PH_W'(1);
        end
      end
      S_EVAL: begin
        if (phase == PH_W'(SETTLE_CYC - 1)) begin
          state_n = S_CAPT;
          phase_n = '0;
        end else begin
          phase_n = phase + PH_W'(1);
        end
      end
      S_CAPT: begin
        cap_n      = sync[SYNC_STAGES-1];
        idx_n      = '0;
        cap_left_n = 1'b1;
        state_n    = S_PACK;
      end
      S_PACK: begin
        // A full word is published before any further capture bits are consumed.
        if (full_c) begin
          word_n  = acc;
          valid_n = 1'b1;
          state_n = S_HOLD;
        end else if (cap_left) begin
          strobe_c = take_c;
          if (idx == IDX_W'(STEPS - 1)) begin
            cap_left_n = 1'b0;
            idx_n      = '0;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          state_n = i_run ? S_PRECH : S_IDLE;
          phase_n = '0;
        end
      end
      S_HOLD: begin
        if (i_ready) begin
          valid_n = 1'b0;
          clear_c = 1'b1;
          phase_n = '0;
          if (cap_left)   state_n = S_PACK;
          else if (i_run) state_n = S_PRECH;
          else            state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    enb_n  = (state_n == S_EVAL);
    busy_n = (state_n != S_IDLE);
  end

endmodule
